// File: rtl/srlatch_ctrl.sv
// rtl/srlatch_ctrl.sv - round-robin set/reset client arbiter driving a shared SR latch

module srlatch_ctrl_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic d_sync
);

    logic d_meta;

    // two-flop synchroniser for the asynchronous latch output
    always_ff @(posedge clk) begin
        if (rst) begin
            d_meta <= 1'b0;
            d_sync <= 1'b0;
        end else begin
            d_meta <= d;
            d_sync <= d_meta;
        end
    end

endmodule

module srlatch_ctrl #(
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    output logic set_ack,
    input  logic rst_req,
    output logic rst_ack,
    output logic s,
    output logic r,
    input  logic q,
    output logic busy,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        HOLD    = 3'd2,
        RELEASE = 3'd3,
        ACK     = 3'd4
    } state_t;

    typedef enum logic {
        TGT_RESET = 1'b0,
        TGT_SET   = 1'b1
    } tgt_t;

    state_t           state;
    tgt_t             target;
    tgt_t             last_grant;
    logic [CNT_W-1:0] cnt;
    logic             q_sync;
    logic             pick_set;
    logic             granted_req;
    logic             q_confirmed;

    srlatch_ctrl_sync u_q_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (q),
        .d_sync (q_sync)
    );

    // A lone request wins outright; under contention the client not granted last time wins.
    assign pick_set    = set_req && (!rst_req || (last_grant == TGT_RESET));
    assign granted_req = (target == TGT_SET) ? set_req : rst_req;
    assign q_confirmed = (q_sync == (target == TGT_SET));

    // Transaction sequencer; outputs are set on the transition into each state so they stay registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            target     <= TGT_RESET;
            last_grant <= TGT_RESET;
            cnt        <= '0;
            s          <= 1'b0;
            r          <= 1'b0;
            set_ack    <= 1'b0;
            rst_ack    <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (set_req || rst_req) begin
                        state  <= DRIVE;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        target <= pick_set ? TGT_SET : TGT_RESET;
                        s      <= pick_set;
                        r      <= !pick_set;
                        if (set_req && rst_req) begin
                            last_grant <= pick_set ? TGT_SET : TGT_RESET;
                        end
                    end
                end
                DRIVE: begin
                    if (q_confirmed) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        err   <= 1'b1;
                        s     <= 1'b0;
                        r     <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        s     <= 1'b0;
                        r     <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    state   <= ACK;
                    set_ack <= (target == TGT_SET);
                    rst_ack <= (target == TGT_RESET);
                end
                ACK: begin
                    if (!granted_req) begin
                        state   <= IDLE;
                        set_ack <= 1'b0;
                        rst_ack <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    s       <= 1'b0;
                    r       <= 1'b0;
                    set_ack <= 1'b0;
                    rst_ack <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srlatch_ctrl.sv
// tb/tb_srlatch_ctrl.sv - directed self-checking bench for srlatch_ctrl

module tb_srlatch_ctrl;

    logic clk;
    logic rst;
    logic set_req;
    logic set_ack;
    logic rst_req;
    logic rst_ack;
    logic s;
    logic r;
    logic q;
    logic busy;
    logic err;

    logic q_lat = 1'b0;
    logic stuck0;

    int checks;
    int errors;

    srlatch_ctrl #(
        .HOLD_CYCLES (2),
        .TIMEOUT     (16),
        .CNT_W       (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .set_req (set_req),
        .set_ack (set_ack),
        .rst_req (rst_req),
        .rst_ack (rst_ack),
        .s       (s),
        .r       (r),
        .q       (q),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // latch model: q follows s/r immediately; stuck0 pins it low
    always @(s, r) begin
        if (s) q_lat = 1'b1;
        else if (r) q_lat = 1'b0;
    end
    assign q = stuck0 ? 1'b0 : q_lat;

    // s and r must never be driven together
    always @(negedge clk) begin
        checks++;
        assert (!(s && r)) else begin
            errors++;
            $error("FAIL s_r_exclusive: observed s=%0b r=%0b required not both 1", s, r);
        end
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_s"}, s, 1'b0);
        chk({tag, "_r"}, r, 1'b0);
        chk({tag, "_set_ack"}, set_ack, 1'b0);
        chk({tag, "_rst_ack"}, rst_ack, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    // n_drive cycles of drive, one release cycle, then the ack cycle
    task automatic txn(input string tag, input logic is_set, input int n_drive);
        for (int i = 0; i < n_drive; i++) begin
            @(negedge clk);
            chk({tag, "_drv_s"}, s, is_set);
            chk({tag, "_drv_r"}, r, !is_set);
            chk({tag, "_drv_set_ack"}, set_ack, 1'b0);
            chk({tag, "_drv_rst_ack"}, rst_ack, 1'b0);
            chk({tag, "_drv_busy"}, busy, 1'b1);
        end
        @(negedge clk);
        chk({tag, "_rel_s"}, s, 1'b0);
        chk({tag, "_rel_r"}, r, 1'b0);
        chk({tag, "_rel_set_ack"}, set_ack, 1'b0);
        chk({tag, "_rel_rst_ack"}, rst_ack, 1'b0);
        chk({tag, "_rel_busy"}, busy, 1'b1);
        @(negedge clk);
        chk({tag, "_ack_set_ack"}, set_ack, is_set);
        chk({tag, "_ack_rst_ack"}, rst_ack, !is_set);
        chk({tag, "_ack_s"}, s, 1'b0);
        chk({tag, "_ack_r"}, r, 1'b0);
        chk({tag, "_ack_busy"}, busy, 1'b1);
    endtask

    task automatic drop(input string tag, input logic is_set);
        if (is_set) set_req = 1'b0;
        else rst_req = 1'b0;
        @(negedge clk);
        chk({tag, "_drop_set_ack"}, set_ack, 1'b0);
        chk({tag, "_drop_rst_ack"}, rst_ack, 1'b0);
        chk({tag, "_drop_busy"}, busy, 1'b0);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        set_req = 1'b0;
        rst_req = 1'b0;
        stuck0  = 1'b0;

        // reset state
        @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_err", err, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // 1: basic set, ack at edge 6, held while req high
        set_req = 1'b1;
        txn("t1_set", 1'b1, 5);
        @(negedge clk);
        chk("t1_ack_held", set_ack, 1'b1);
        chk("t1_q", q, 1'b1);
        drop("t1", 1'b1);
        chk("t1_err", err, 1'b0);

        // 2: basic reset
        rst_req = 1'b1;
        txn("t2_rst", 1'b0, 5);
        chk("t2_q", q, 1'b0);
        drop("t2", 1'b0);

        // 3: contention after reset goes SET first, then RESET; next contention RESET first
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("t3_reset");
        rst = 1'b0;
        set_req = 1'b1;
        rst_req = 1'b1;
        txn("t3_a_set", 1'b1, 5);
        drop("t3_a", 1'b1);
        txn("t3_a_rst", 1'b0, 5);
        drop("t3_a2", 1'b0);
        set_req = 1'b1;
        rst_req = 1'b1;
        txn("t3_b_rst", 1'b0, 3);
        drop("t3_b", 1'b0);
        txn("t3_b_set", 1'b1, 5);
        drop("t3_b2", 1'b1);

        // 4: timeout with latch stuck low; err sticky across later transaction
        stuck0 = 1'b1;
        repeat (3) @(negedge clk);
        set_req = 1'b1;
        txn("t4_to", 1'b1, 16);
        chk("t4_err_set", err, 1'b1);
        drop("t4", 1'b1);
        chk("t4_err_after_drop", err, 1'b1);
        stuck0 = 1'b0;
        repeat (3) @(negedge clk);
        rst_req = 1'b1;
        txn("t4_rst", 1'b0, 5);
        chk("t4_err_sticky", err, 1'b1);
        drop("t4b", 1'b0);
        chk("t4_err_sticky2", err, 1'b1);

        // 5: reset during HOLD, then contention granted to SET
        set_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("t5_in_hold_s", s, 1'b1);
        chk("t5_in_hold_busy", busy, 1'b1);
        rst = 1'b1;
        set_req = 1'b0;
        @(negedge clk);
        chk_idle_outputs("t5_reset");
        chk("t5_reset_err", err, 1'b0);
        rst = 1'b0;
        set_req = 1'b1;
        rst_req = 1'b1;
        txn("t5_set", 1'b1, 4);
        drop("t5", 1'b1);
        txn("t5_rst", 1'b0, 5);
        drop("t5b", 1'b0);

        // 6: latch already set, req pulsed two cycles, ack lasts one cycle
        set_req = 1'b1;
        txn("t6_pre", 1'b1, 5);
        drop("t6_pre", 1'b1);
        set_req = 1'b1;
        @(negedge clk);
        chk("t6_e0_s", s, 1'b1);
        @(negedge clk);
        chk("t6_e1_s", s, 1'b1);
        set_req = 1'b0;
        @(negedge clk);
        chk("t6_e2_s", s, 1'b1);
        @(negedge clk);
        chk("t6_e3_s", s, 1'b0);
        chk("t6_e3_ack", set_ack, 1'b0);
        @(negedge clk);
        chk("t6_e4_ack", set_ack, 1'b1);
        chk("t6_e4_busy", busy, 1'b1);
        rst_req = 1'b1;
        @(negedge clk);
        chk("t6_e5_ack", set_ack, 1'b0);
        chk("t6_e5_busy", busy, 1'b0);
        chk("t6_e5_r", r, 1'b0);
        txn("t6_rst", 1'b0, 5);
        drop("t6", 1'b0);
        chk("t6_q", q, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
